// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide sequencer states, op encodings, widths.
package cpu_pkg;

  // Operand width shared with the control unit and the HI/LO registers
  localparam int unsigned MD_DATA_W = 32;
  // Iteration counter width; 2**MD_CNT_W must exceed MD_DATA_W
  localparam int unsigned MD_CNT_W  = 6;

  // op_div encodings
  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

  // Multiply/divide sequencer states
  typedef enum logic [2:0] {
    MD_IDLE   = 3'd0,
    MD_MULT   = 3'd1,
    MD_DIV    = 3'd2,
    MD_FIXUP  = 3'd3,
    MD_FINISH = 3'd4
  } md_state_t;

endpackage : cpu_pkg

// File: rtl/mult_div_seq_if.sv
// Request/response bundle between the CPU control unit and the mult/div sequencer.
interface mult_div_seq_if #(
  parameter int unsigned DATA_W = cpu_pkg::MD_DATA_W
);

  logic              start;
  logic              op_div;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  // Control unit side: issues requests, consumes results
  modport master (
    output start, op_div, a, b,
    input  busy, done, div_zero, hi, lo
  );

  // Sequencer side
  modport slave (
    input  start, op_div, a, b,
    output busy, done, div_zero, hi, lo
  );

endinterface : mult_div_seq_if

// File: rtl/md_datapath.sv
// Shared shift/add datapath for signed Booth multiply and restoring divide.
// Shift register layout (2*DATA_W+1 bits): {upper, lower, extra}
//   MULT: {accumulator, multiplier, booth q(-1)}
//   DIV : {remainder,   quotient,   unused}
module md_datapath import cpu_pkg::*; #(
  parameter int unsigned DATA_W = MD_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_op_div,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_step_mult,
  input  logic              i_step_div,
  input  logic              i_fixup,
  input  logic              i_neg_q,
  input  logic              i_neg_r,
  output logic [DATA_W-1:0] o_hi_nxt_c,
  output logic [DATA_W-1:0] o_lo_nxt_c
);

  localparam int unsigned SR_W  = 2 * DATA_W + 1;
  localparam int unsigned EXT_W = DATA_W + 1;

  logic [SR_W-1:0]   r_sr;
  logic [SR_W-1:0]   w_sr_nxt;
  logic [EXT_W-1:0]  r_m;
  logic [EXT_W-1:0]  w_a_ext;
  logic [EXT_W-1:0]  w_b_ext;
  logic [EXT_W-1:0]  w_abs_a;
  logic [EXT_W-1:0]  w_abs_b;
  logic [EXT_W-1:0]  w_opa;
  logic [EXT_W-1:0]  w_opb;
  logic [EXT_W-1:0]  w_sum;
  logic              w_booth_add;
  logic              w_booth_sub;
  logic              w_sub;
  logic              w_qbit;
  logic [DATA_W-1:0] w_upper;
  logic [DATA_W-1:0] w_lower;
  logic [DATA_W-1:0] w_rem_new;

  assign w_upper = r_sr[SR_W-1 -: DATA_W];
  assign w_lower = r_sr[DATA_W -: DATA_W];

  // Magnitudes in DATA_W+1 bits so the most-negative operand yields +2**(DATA_W-1)
  assign w_a_ext = {i_a[DATA_W-1], i_a};
  assign w_b_ext = {i_b[DATA_W-1], i_b};
  assign w_abs_a = i_a[DATA_W-1] ? (~w_a_ext + EXT_W'(1)) : w_a_ext;
  assign w_abs_b = i_b[DATA_W-1] ? (~w_b_ext + EXT_W'(1)) : w_b_ext;

  // Booth recoding of {q0, q(-1)}: 01 adds, 10 subtracts the multiplicand
  assign w_booth_add = ~r_sr[1] &  r_sr[0];
  assign w_booth_sub =  r_sr[1] & ~r_sr[0];

  // Single DATA_W+1 adder/subtractor; divide always subtracts the divisor
  assign w_sub = i_step_div | w_booth_sub;
  assign w_opa = i_step_div ? r_sr[SR_W-1 -: EXT_W] : {r_sr[SR_W-1], w_upper};
  assign w_opb = (i_step_div | w_booth_add | w_booth_sub) ? r_m : '0;
  assign w_sum = w_opa + (w_sub ? ~w_opb : w_opb) + EXT_W'(w_sub);

  // Restoring step: keep the difference only when it did not go negative
  assign w_qbit    = ~w_sum[DATA_W];
  assign w_rem_new = w_qbit ? w_sum[DATA_W-1:0] : r_sr[SR_W-2 -: DATA_W];

  // Next shift-register value for load, Booth step, divide step or sign fixup
  always_comb begin
    w_sr_nxt = r_sr;
    if (i_load) begin
      if (i_op_div) begin
        w_sr_nxt = {(DATA_W-1)'(0), w_abs_a, 1'b0};
      end else begin
        w_sr_nxt = {DATA_W'(0), i_b, 1'b0};
      end
    end else if (i_step_mult) begin
      // Arithmetic shift right of the full-precision sum concatenated with the multiplier
      w_sr_nxt = {w_sum, w_lower};
    end else if (i_step_div) begin
      w_sr_nxt = {w_rem_new, r_sr[DATA_W-1:1], w_qbit, 1'b0};
    end else if (i_fixup) begin
      w_sr_nxt = {i_neg_r ? (~w_upper + DATA_W'(1)) : w_upper,
                  i_neg_q ? (~w_lower + DATA_W'(1)) : w_lower,
                  r_sr[0]};
    end
  end

  // Shift register update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr <= '0;
    end else begin
      r_sr <= w_sr_nxt;
    end
  end

  // Multiplicand (sign-extended) or divisor magnitude, captured at load
  always_ff @(posedge clk) begin
    if (reset) begin
      r_m <= '0;
    end else if (i_load) begin
      r_m <= i_op_div ? w_abs_b : w_a_ext;
    end
  end

  // Results as they will be after this edge, so the FSM can register them on completion
  assign o_hi_nxt_c = w_sr_nxt[SR_W-1 -: DATA_W];
  assign o_lo_nxt_c = w_sr_nxt[DATA_W -: DATA_W];

endmodule : md_datapath

// File: rtl/mult_div_seq.sv
// Iterative signed multiply/divide sequencer driving the CPU HI/LO registers.
module mult_div_seq import cpu_pkg::*; #(
  parameter int unsigned DATA_W = MD_DATA_W,
  parameter int unsigned CNT_W  = MD_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_seq_if.slave md
);

  md_state_t         r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sign_a;
  logic              r_sign_b;
  logic              r_busy;
  logic              r_done;
  logic              r_div_zero;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic              w_load;
  logic              w_step_mult;
  logic              w_step_div;
  logic              w_fixup;
  logic              w_last;
  logic [DATA_W-1:0] w_hi_nxt;
  logic [DATA_W-1:0] w_lo_nxt;

  // Datapath strobes decoded from the current state
  assign w_load      = (r_state == MD_IDLE) & md.start;
  assign w_step_mult = (r_state == MD_MULT);
  assign w_step_div  = (r_state == MD_DIV);
  assign w_fixup     = (r_state == MD_FIXUP);
  assign w_last      = (r_cnt == CNT_W'(DATA_W - 1));

  md_datapath #(
    .DATA_W (DATA_W)
  ) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_load),
    .i_op_div    (md.op_div),
    .i_a         (md.a),
    .i_b         (md.b),
    .i_step_mult (w_step_mult),
    .i_step_div  (w_step_div),
    .i_fixup     (w_fixup),
    .i_neg_q     (r_sign_a ^ r_sign_b),
    .i_neg_r     (r_sign_a),
    .o_hi_nxt_c  (w_hi_nxt),
    .o_lo_nxt_c  (w_lo_nxt)
  );

  // Sequencing FSM, iteration counter, sign flags and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= MD_IDLE;
      r_cnt      <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
    end else begin
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (md.start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            if (md.op_div == MD_OP_MULT) begin
              r_state <= MD_MULT;
            end else if (md.b == '0) begin
              // Divide by zero: finish immediately, HI/LO keep the previous result
              r_state    <= MD_FINISH;
              r_done     <= 1'b1;
              r_div_zero <= 1'b1;
            end else begin
              r_state  <= MD_DIV;
              r_sign_a <= md.a[DATA_W-1];
              r_sign_b <= md.b[DATA_W-1];
            end
          end
        end
        MD_MULT: begin
          if (w_last) begin
            r_state <= MD_FINISH;
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        MD_DIV: begin
          if (w_last) begin
            r_state <= MD_FIXUP;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        MD_FIXUP: begin
          r_state <= MD_FINISH;
          r_done  <= 1'b1;
          r_hi    <= w_hi_nxt;
          r_lo    <= w_lo_nxt;
        end
        MD_FINISH: begin
          r_state <= MD_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= MD_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy     = r_busy;
  assign md.done     = r_done;
  assign md.div_zero = r_div_zero;
  assign md.hi       = r_hi;
  assign md.lo       = r_lo;

endmodule : mult_div_seq

// File: tb/tb_mult_div_seq.sv
// Directed testbench for mult_div_seq with hand-computed expected results.
module tb_mult_div_seq;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  mult_div_seq_if md_bus ();

  mult_div_seq dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, optionally pulse start again at poke_cyc, and check the result
  task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e_hi,
                        input logic [31:0] e_lo, input logic e_dz,
                        input int e_lat, input int poke_cyc);
    int   lat;
    logic got_dz;
    lat    = 0;
    got_dz = 1'b0;
    md_bus.start  = 1'b1;
    md_bus.op_div = op;
    md_bus.a      = a;
    md_bus.b      = b;
    @(posedge clk); #1;
    md_bus.start = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (cyc == 1) check_eq({tag, "_busy1"}, 64'(md_bus.busy), 64'h1);
      if (cyc == 2) begin
        check_eq({tag, "_hold_hi"}, 64'(md_bus.hi), 64'(prev_hi));
        check_eq({tag, "_hold_lo"}, 64'(md_bus.lo), 64'(prev_lo));
      end
      if (md_bus.done) begin
        lat    = cyc;
        got_dz = md_bus.div_zero;
        break;
      end
      if (cyc == poke_cyc) begin
        md_bus.start  = 1'b1;
        md_bus.op_div = ~op;
        md_bus.a      = 32'h1;
        md_bus.b      = 32'h1;
      end else begin
        md_bus.start = 1'b0;
      end
      @(posedge clk); #1;
    end
    md_bus.start = 1'b0;
    check_eq({tag, "_lat"}, 64'(lat), 64'(e_lat));
    check_eq({tag, "_hi"}, 64'(md_bus.hi), 64'(e_hi));
    check_eq({tag, "_lo"}, 64'(md_bus.lo), 64'(e_lo));
    check_eq({tag, "_dz"}, 64'(got_dz), 64'(e_dz));
    @(posedge clk); #1;
    check_eq({tag, "_done_off"}, 64'(md_bus.done), 64'h0);
    check_eq({tag, "_busy_off"}, 64'(md_bus.busy), 64'h0);
    check_eq({tag, "_held_lo"}, 64'(md_bus.lo), 64'(e_lo));
    prev_hi = e_hi;
    prev_lo = e_lo;
  endtask

  initial begin
    int n_done;
    reset         = 1'b1;
    md_bus.start  = 1'b0;
    md_bus.op_div = MD_OP_MULT;
    md_bus.a      = '0;
    md_bus.b      = '0;
    prev_hi       = '0;
    prev_lo       = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", 64'(md_bus.busy), 64'h0);
    check_eq("rst_done", 64'(md_bus.done), 64'h0);
    check_eq("rst_dz", 64'(md_bus.div_zero), 64'h0);
    check_eq("rst_hi", 64'(md_bus.hi), 64'h0);
    check_eq("rst_lo", 64'(md_bus.lo), 64'h0);
    reset = 1'b0;

    run_op("mul_7_m3", MD_OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 0);
    run_op("mul_min_min", MD_OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 33, 0);
    run_op("mul_max_max", MD_OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 33, 0);
    run_op("mul_m1_m1", MD_OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0, 33, 0);
    run_op("div_m7_2", MD_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34, 0);
    run_op("div_7_m2", MD_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0, 34, 0);
    run_op("div_min_m1", MD_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 34, 0);
    run_op("div_5_0", MD_OP_DIV, 32'd5, 32'd0, 32'h0, 32'h8000_0000, 1'b1, 1, 0);
    run_op("div_100_7_poke", MD_OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 34, 10);

    // Reset in the middle of a multiply: abort with no done pulse
    md_bus.start  = 1'b1;
    md_bus.op_div = MD_OP_MULT;
    md_bus.a      = 32'd5;
    md_bus.b      = 32'd6;
    @(posedge clk); #1;
    md_bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_eq("abort_busy_before", 64'(md_bus.busy), 64'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("abort_busy", 64'(md_bus.busy), 64'h0);
    check_eq("abort_done", 64'(md_bus.done), 64'h0);
    check_eq("abort_hi", 64'(md_bus.hi), 64'h0);
    check_eq("abort_lo", 64'(md_bus.lo), 64'h0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (md_bus.done) n_done++;
    end
    check_eq("abort_no_done", 64'(n_done), 64'h0);
    prev_hi = '0;
    prev_lo = '0;

    // Start together with reset: reset wins
    reset         = 1'b1;
    md_bus.start  = 1'b1;
    md_bus.op_div = MD_OP_MULT;
    @(posedge clk); #1;
    reset        = 1'b0;
    md_bus.start = 1'b0;
    check_eq("rst_start_busy", 64'(md_bus.busy), 64'h0);

    run_op("mul_3_4", MD_OP_MULT, 32'd3, 32'd4, 32'h0, 32'd12, 1'b0, 33, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mult_div_seq
